truth_sweep: RTL



---
 rtl/truth_sweep_pkg.sv | 21 ++
 rtl/truth_sweep_if.sv | 35 +++
 rtl/truth_sweep.sv | 116 +++++++++++
 3 files changed

// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweep sequencer.
// Holds the FSM encoding, the default table width and the reference table of (x|y)&~z.
package truth_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int N_IN_DEF = 3;
    localparam int TT_W     = 2 ** N_IN_DEF;

    // Expected table of (x|y)&~z, bit index {x,y,z}.
    localparam logic [TT_W-1:0] FXYZ_TT = 8'h54;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_sweep_if.sv
// Bundle between the sweep sequencer and whoever controls it and closes the loop
// through the function under test.
interface truth_sweep_if
    import truth_sweep_pkg::*;
#(
    parameter int N_IN = 3
) ();
    localparam int TW = tt_width(N_IN);

    // start is a level sampled on any edge while IDLE or DONE (ignored in RUN); abort is
    // sampled on every edge and wins over everything; done/tt/ones/mism hold until restart.
    logic             start;
    logic             abort;
    logic [TW-1:0]    expect_tt;
    logic             s;
    logic [N_IN-1:0]  vec;
    logic             busy;
    logic             done;
    logic [TW-1:0]    tt;
    logic [N_IN:0]    ones;
    logic [N_IN:0]    mism;
    logic             pass;
    state_e           dbg_state;

    modport slave (
        input  start, abort, expect_tt, s,
        output vec, busy, done, tt, ones, mism, pass, dbg_state
    );

    modport master (
        output start, abort, expect_tt, s,
        input  vec, busy, done, tt, ones, mism, pass, dbg_state
    );

endinterface

// File: rtl/truth_sweep.sv
// Walks every input vector of an N_IN-input combinational block, samples its output after
// SETTLE cycles per vector, builds the truth table and scores it against expect_tt.
module truth_sweep
    import truth_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    truth_sweep_if.slave bus
);
    localparam int TW = tt_width(N_IN);

    localparam logic [3:0]      LAST_CNT = 4'(SETTLE - 1);
    localparam logic [3:0]      CNT_ONE  = 4'd1;
    localparam logic [N_IN-1:0] VEC_MAX  = N_IN'(TW - 1);
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   SUM_ONE  = (N_IN + 1)'(1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [TW-1:0]   tt_q, tt_d;
    logic [N_IN:0]   ones_q, ones_d;
    logic [N_IN:0]   mism_q, mism_d;

    logic            s_one;
    logic            sample_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            mism_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            mism_q  <= mism_d;
        end
    end

    // An unknown or floating s counts as 0 for the scores; tt still keeps the raw value.
    assign s_one      = (bus.s === 1'b1);
    assign sample_now = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        mism_d  = mism_q;

        if (bus.abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            vec_d   = '0;
            tt_d    = '0;
            ones_d  = '0;
            mism_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        vec_d   = '0;
                        tt_d    = '0;
                        ones_d  = '0;
                        mism_d  = '0;
                    end
                end
                ST_RUN: begin
                    if (sample_now) begin
                        tt_d[vec_q] = bus.s;
                        if (s_one) begin
                            ones_d = ones_q + SUM_ONE;
                        end
                        if (s_one != bus.expect_tt[vec_q]) begin
                            mism_d = mism_q + SUM_ONE;
                        end
                        // The last vector stays on the bus after the sweep instead of wrapping.
                        if (vec_q == VEC_MAX) begin
                            state_d = ST_DONE;
                        end else begin
                            vec_d = vec_q + VEC_ONE;
                            cnt_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.vec       = vec_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.tt        = tt_q;
    assign bus.ones      = ones_q;
    assign bus.mism      = mism_q;
    assign bus.pass      = (state_q == ST_DONE) && (mism_q == '0);
    assign bus.dbg_state = state_q;

endmodule
